// File: rtl/f9pcap_unwrap_eth_pkg.sv
// Shared f9pcap wrapper layout: ETH/IP/UDP/f9phdr byte offsets and
// field constants, used by both the wrap and unwrap sides.
package f9pcap_unwrap_eth_pkg;

   localparam int WRAP_HDR_LENGTH = 58;
   localparam int F9PHDR_LENGTH   = 16;

   localparam int ETH_TYPE_OFS    = 12;
   localparam int IP_VER_OFS      = 14;
   localparam int IP_PROTO_OFS    = 23;
   localparam int IP_DST_OFS      = 30;
   localparam int UDP_DST_OFS     = 36;
   localparam int F9P_TTS_OFS     = 42;
   localparam int F9P_TTS_END     = 47;
   localparam int F9P_PORT_OFS    = 48;
   localparam int F9P_FLAGS_OFS   = 49;
   localparam int F9P_CAPLEN_OFS  = 50;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
   localparam int F9PHDR_FLAG_FRAME_ERR   = 0;

   // Bytes without a filter rule always pass.
   function automatic logic hdr_byte_ok(
      input logic [5:0]  idx,
      input logic [7:0]  b,
      input logic [31:0] addr,
      input logic [15:0] port
   );
      logic ok;
      ok = 1'b1;
      unique case (1'b1)
         (idx == 6'(ETH_TYPE_OFS)):    ok = (b == ETHERTYPE_IPV4[15:8]);
         (idx == 6'(ETH_TYPE_OFS+1)):  ok = (b == ETHERTYPE_IPV4[7:0]);
         (idx == 6'(IP_VER_OFS)):      ok = (b == IP_VER_IHL);
         (idx == 6'(IP_PROTO_OFS)):    ok = (b == IP_PROTO_UDP);
         (idx == 6'(IP_DST_OFS)):      ok = (b == addr[31:24]);
         (idx == 6'(IP_DST_OFS+1)):    ok = (b == addr[23:16]);
         (idx == 6'(IP_DST_OFS+2)):    ok = (b == addr[15:8]);
         (idx == 6'(IP_DST_OFS+3)):    ok = (b == addr[7:0]);
         (idx == 6'(UDP_DST_OFS)):     ok = (b == port[15:8]);
         (idx == 6'(UDP_DST_OFS+1)):   ok = (b == port[7:0]);
         default:                      ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/f9pcap_unwrap_eth.sv
// Strips the ETH/IP/UDP/f9phdr wrapper from a filtered f9pcap stream
// and re-emits the captured frame with f9phdr fields as sideband.
import f9pcap_unwrap_eth_pkg::*;

module f9pcap_unwrap_eth #(
   parameter int TTS_WIDTH  = 48,
   parameter int CNT_WIDTH  = 16,
   parameter int HDR_LENGTH = WRAP_HDR_LENGTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [31:0]          f9pcap_mcgroup_addr,
   input  logic [15:0]          f9pcap_mcgroup_port,
   input  logic                 i_valid_in,
   output logic                 i_ready_out,
   input  logic [7:0]           i_data_in,
   input  logic                 i_last_in,
   output logic                 o_valid_out,
   input  logic                 o_ready_in,
   output logic [7:0]           o_data_out,
   output logic                 o_last_out,
   output logic                 o_err_out,
   output logic [TTS_WIDTH-1:0] o_tts_out,
   output logic [7:0]           o_port_id_out,
   output logic [15:0]          o_cap_len_out,
   output logic [CNT_WIDTH-1:0] frames_ok_out,
   output logic [CNT_WIDTH-1:0] frames_drop_out
);

   typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DISCARD} state_t;

   state_t state_q, state_d;

   logic [5:0]           hcnt_q;
   logic [15:0]          pcnt_q;
   logic                 rdy_q;
   logic                 match_q;
   logic                 ferr_q;
   logic [TTS_WIDTH-1:0] tts_sh;
   logic [7:0]           port_sh;
   logic [7:0]           flags_sh;
   logic [15:0]          cap_sh;

   logic in_acc, hdr_end, byte_ok, match_now, fwd, pay_last;

   assign in_acc    = i_valid_in & i_ready_out;
   assign hdr_end   = (hcnt_q == 6'(HDR_LENGTH-1));
   assign byte_ok   = hdr_byte_ok(hcnt_q, i_data_in,
                                  f9pcap_mcgroup_addr,
                                  f9pcap_mcgroup_port);
   assign match_now = ((hcnt_q == 6'd0) | match_q) & byte_ok;
   assign fwd       = match_now & (cap_sh != 16'd0) & ~i_last_in;
   assign pay_last  = (pcnt_q == 16'd1) | i_last_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= S_HDR;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HDR: begin
            if (in_acc && hdr_end)
               state_d = fwd ? S_PAYLOAD
                             : (i_last_in ? S_HDR : S_DISCARD);
         end
         S_PAYLOAD: begin
            if (in_acc && pay_last)
               state_d = i_last_in ? S_HDR : S_DISCARD;
         end
         S_DISCARD: begin
            if (in_acc && i_last_in) state_d = S_HDR;
         end
         default: state_d = S_HDR;
      endcase
   end

   // Payload is a zero-latency pass-through so backpressure is combinational.
   always_comb begin
      i_ready_out = 1'b0;
      o_valid_out = 1'b0;
      o_data_out  = 8'd0;
      o_last_out  = 1'b0;
      o_err_out   = 1'b0;
      unique case (state_q)
         S_PAYLOAD: begin
            i_ready_out = o_ready_in;
            o_valid_out = i_valid_in;
            o_data_out  = i_data_in;
            o_last_out  = pay_last;
            o_err_out   = pay_last &
                          ((i_last_in & (pcnt_q > 16'd1)) | ferr_q);
         end
         default: i_ready_out = rdy_q;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rdy_q           <= 1'b0;
         hcnt_q          <= 6'd0;
         pcnt_q          <= 16'd0;
         match_q         <= 1'b0;
         ferr_q          <= 1'b0;
         tts_sh          <= '0;
         port_sh         <= 8'd0;
         flags_sh        <= 8'd0;
         cap_sh          <= 16'd0;
         o_tts_out       <= '0;
         o_port_id_out   <= 8'd0;
         o_cap_len_out   <= 16'd0;
         frames_ok_out   <= '0;
         frames_drop_out <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (in_acc && state_q == S_HDR) begin
            hcnt_q  <= (hdr_end | i_last_in) ? 6'd0 : hcnt_q + 6'd1;
            match_q <= match_now;
            if (hcnt_q >= 6'(F9P_TTS_OFS) && hcnt_q <= 6'(F9P_TTS_END))
               tts_sh <= {tts_sh[TTS_WIDTH-9:0], i_data_in};
            if (hcnt_q == 6'(F9P_PORT_OFS))
               port_sh <= i_data_in;
            if (hcnt_q == 6'(F9P_FLAGS_OFS))
               flags_sh <= i_data_in;
            if (hcnt_q == 6'(F9P_CAPLEN_OFS) ||
                hcnt_q == 6'(F9P_CAPLEN_OFS+1))
               cap_sh <= {cap_sh[7:0], i_data_in};
            if (hdr_end && fwd) begin
               pcnt_q        <= cap_sh;
               ferr_q        <= flags_sh[F9PHDR_FLAG_FRAME_ERR];
               o_tts_out     <= tts_sh;
               o_port_id_out <= port_sh;
               o_cap_len_out <= cap_sh;
            end
            if ((hdr_end && !fwd) || (!hdr_end && i_last_in))
               if (~&frames_drop_out)
                  frames_drop_out <= frames_drop_out + 1'b1;
         end
         if (in_acc && state_q == S_PAYLOAD) begin
            pcnt_q <= pcnt_q - 16'd1;
            if (pay_last && ~&frames_ok_out)
               frames_ok_out <= frames_ok_out + 1'b1;
         end
         if (in_acc && state_q == S_DISCARD && i_last_in)
            hcnt_q <= 6'd0;
      end
   end

endmodule
